// File: rtl/div_unit_if.sv
// rtl/div_unit_if.sv - request/result bundle between the EX stage and div_unit
interface div_unit_if;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );
endinterface

// File: rtl/div_unit.sv
// rtl/div_unit.sv - 32-bit signed/unsigned restoring divider, one quotient bit per cycle
module div_unit (
  input  logic     clk,
  input  logic     rst,
  div_unit_if.slave bus
);

  typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

  state_t      state, state_nx;
  logic [5:0]  cnt;
  logic [64:0] acc;        // {partial remainder, dividend -> quotient}
  logic [31:0] dvs;
  logic        neg_q, neg_r;

  logic        latch_en, step_en, finish_en;
  logic [31:0] a_mag, b_mag;
  logic [33:0] trial;
  logic [64:0] acc_step;
  logic [31:0] quo_fix, rem_fix;

  always_ff @(posedge clk) begin
    if (rst) state <= FREE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      FREE:    if (bus.start_i && !bus.annul_i)
                 state_nx = (bus.opdata2_i == 32'h0) ? BYZERO : ON;
      BYZERO:  state_nx = END;
      ON:      if (bus.annul_i)          state_nx = FREE;
               else if (cnt == 6'd32)    state_nx = END;
      END:     if (!bus.start_i)         state_nx = FREE;
      default: state_nx = FREE;
    endcase
  end

  always_comb begin
    latch_en  = 1'b0;
    step_en   = 1'b0;
    finish_en = 1'b0;
    case (state)
      FREE:    latch_en  = bus.start_i && !bus.annul_i;
      ON: begin
        step_en   = !bus.annul_i && (cnt != 6'd32);
        finish_en = !bus.annul_i && (cnt == 6'd32);
      end
      default: ;
    endcase
  end

  // Operands are reduced to magnitudes at latch time; signs are kept only as fix-up flags.
  always_comb begin
    a_mag = (bus.signed_div_i && bus.opdata1_i[31]) ? -bus.opdata1_i : bus.opdata1_i;
    b_mag = (bus.signed_div_i && bus.opdata2_i[31]) ? -bus.opdata2_i : bus.opdata2_i;
  end

  // acc[64:31] is the remainder already shifted left by one, so trial[33] is the borrow.
  always_comb begin
    trial    = acc[64:31] - {2'b00, dvs};
    acc_step = trial[33] ? {acc[63:0], 1'b0}
                         : {trial[32:0], acc[30:0], 1'b1};
    quo_fix  = neg_q ? -acc[31:0]  : acc[31:0];
    rem_fix  = neg_r ? -acc[63:32] : acc[63:32];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt          <= 6'd0;
      acc          <= 65'h0;
      dvs          <= 32'h0;
      neg_q        <= 1'b0;
      neg_r        <= 1'b0;
      bus.ready_o  <= 1'b0;
      bus.result_o <= 64'h0;
    end else begin
      if (latch_en) begin
        acc   <= {33'h0, a_mag};
        dvs   <= b_mag;
        neg_q <= bus.signed_div_i && (bus.opdata1_i[31] ^ bus.opdata2_i[31]);
        neg_r <= bus.signed_div_i && bus.opdata1_i[31];
        cnt   <= 6'd0;
      end else if (step_en) begin
        acc <= acc_step;
        cnt <= cnt + 6'd1;
      end

      bus.ready_o <= (state_nx == END);
      if (finish_en)
        bus.result_o <= {rem_fix, quo_fix};
      else if (state_nx != END)
        bus.result_o <= 64'h0;
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - self-checking bench for div_unit against an arithmetic reference model
module tb_div_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  div_unit_if bus ();

  div_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests_run = 0;
  int fails     = 0;

  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint la, lb, q, r;
    int     ia, ib;
    if (b == 32'h0) return 64'h0;
    if (s) begin
      ia = a; ib = b;
      la = ia; lb = ib;
    end else begin
      la = {32'h0, a};
      lb = {32'h0, b};
    end
    q = la / lb;
    r = la % lb;
    return {r[31:0], q[31:0]};
  endfunction

  // Issues a request, scrambles operands after acceptance, and waits (bounded) for ready_o.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                         output logic [63:0] got, output int lat, output int leak);
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.signed_div_i = s;
    bus.annul_i      = 1'b0;
    bus.start_i      = 1'b1;
    @(posedge clk); #1;
    lat  = 0;
    leak = 0;
    while (bus.ready_o !== 1'b1 && lat < 100) begin
      if (bus.result_o !== 64'h0) leak++;
      bus.opdata1_i    = $urandom;
      bus.opdata2_i    = $urandom;
      bus.signed_div_i = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      lat++;
    end
    got = bus.result_o;
  endtask

  task automatic release_div();
    bus.start_i = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst              = 1'b1;
    bus.start_i      = 1'b1;
    bus.annul_i      = 1'b0;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd5;
    bus.opdata2_i    = 32'd1;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (bus.ready_o !== 1'b0 || bus.result_o !== 64'h0) begin
      fails++;
      $display("FAIL reset_state: ready=%b result=%h, required ready=0 result=0", bus.ready_o, bus.result_o);
    end
    rst         = 1'b0;
    bus.start_i = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_vectors();
    logic [31:0] va [3] = '{32'hFFFFFFFF, 32'hFFFFFFF9, 32'h00000007};
    logic [31:0] vb [3] = '{32'h00000002, 32'h00000002, 32'hFFFFFFFE};
    logic        vs [3] = '{1'b0, 1'b1, 1'b1};
    logic [63:0] ve [3] = '{64'h00000001_7FFFFFFF, 64'hFFFFFFFF_FFFFFFFD, 64'h00000001_FFFFFFFD};
    logic [63:0] got;
    int lat, leak;
    for (int i = 0; i < 3; i++) begin
      run_div(va[i], vb[i], vs[i], got, lat, leak);
      tests_run++;
      if (lat !== 33 || got !== ve[i]) begin
        fails++;
        $display("FAIL vector_%0d: latency=%0d result=%h, required latency=33 result=%h", i, lat, got, ve[i]);
      end
      release_div();
      tests_run++;
      if (bus.ready_o !== 1'b0 || bus.result_o !== 64'h0) begin
        fails++;
        $display("FAIL vector_%0d_release: ready=%b result=%h, required ready=0 result=0", i, bus.ready_o, bus.result_o);
      end
    end
  endtask

  task automatic test_div_zero();
    logic [63:0] got;
    int lat, leak;
    run_div(32'h12345678, 32'h0, 1'b0, got, lat, leak);
    tests_run++;
    if (lat !== 1 || got !== 64'h0 || bus.ready_o !== 1'b1) begin
      fails++;
      $display("FAIL div_zero: latency=%0d result=%h ready=%b, required latency=1 result=0 ready=1", lat, got, bus.ready_o);
    end
    release_div();
    tests_run++;
    if (bus.ready_o !== 1'b0) begin
      fails++;
      $display("FAIL div_zero_release: ready=%b, required 0", bus.ready_o);
    end
  endtask

  task automatic test_annul();
    logic [63:0] got;
    int lat, leak, bad;
    bus.opdata1_i    = 32'd1000;
    bus.opdata2_i    = 32'd3;
    bus.signed_div_i = 1'b0;
    bus.annul_i      = 1'b0;
    bus.start_i      = 1'b1;
    @(posedge clk);
    repeat (9) @(posedge clk);
    #1;
    bus.annul_i = 1'b1;
    @(posedge clk); #1;
    bus.annul_i = 1'b0;
    bus.start_i = 1'b0;
    bad = 0;
    repeat (30) begin
      if (bus.ready_o !== 1'b0 || bus.result_o !== 64'h0) bad++;
      @(posedge clk); #1;
    end
    tests_run++;
    if (bad != 0) begin
      fails++;
      $display("FAIL annul_quiet: cycles with ready/result set=%0d, required 0", bad);
    end
    run_div(32'd100, 32'd7, 1'b0, got, lat, leak);
    tests_run++;
    if (lat !== 33 || got !== 64'h00000002_0000000E) begin
      fails++;
      $display("FAIL annul_fresh: latency=%0d result=%h, required latency=33 result=000000020000000e", lat, got);
    end
    release_div();
  endtask

  task automatic test_reset_midop();
    logic [63:0] got;
    int lat, leak, bad;
    bus.opdata1_i    = 32'hDEADBEEF;
    bus.opdata2_i    = 32'd13;
    bus.signed_div_i = 1'b0;
    bus.annul_i      = 1'b0;
    bus.start_i      = 1'b1;
    @(posedge clk);
    repeat (19) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst         = 1'b0;
    bus.start_i = 1'b0;
    bad = 0;
    repeat (40) begin
      if (bus.ready_o !== 1'b0 || bus.result_o !== 64'h0) bad++;
      @(posedge clk); #1;
    end
    tests_run++;
    if (bad != 0) begin
      fails++;
      $display("FAIL reset_midop_quiet: cycles with ready/result set=%0d, required 0", bad);
    end
    run_div(32'd1000000, 32'd999, 1'b0, got, lat, leak);
    tests_run++;
    if (lat !== 33 || got !== ref_div(32'd1000000, 32'd999, 1'b0)) begin
      fails++;
      $display("FAIL reset_midop_next: latency=%0d result=%h, required latency=33 result=%h",
               lat, got, ref_div(32'd1000000, 32'd999, 1'b0));
    end
    release_div();
  endtask

  task automatic test_overflow_hold();
    logic [63:0] got;
    int lat, leak, bad;
    run_div(32'h80000000, 32'hFFFFFFFF, 1'b1, got, lat, leak);
    tests_run++;
    if (lat !== 33 || got !== 64'h00000000_80000000) begin
      fails++;
      $display("FAIL overflow: latency=%0d result=%h, required latency=33 result=0000000080000000", lat, got);
    end
    bad = 0;
    repeat (5) begin
      bus.opdata1_i = $urandom;
      bus.opdata2_i = $urandom;
      @(posedge clk); #1;
      if (bus.ready_o !== 1'b1 || bus.result_o !== 64'h00000000_80000000) bad++;
    end
    tests_run++;
    if (bad != 0) begin
      fails++;
      $display("FAIL overflow_hold: unstable cycles=%0d, required 0", bad);
    end
    release_div();
  endtask

  task automatic test_back_to_back();
    logic [63:0] got1, got2;
    int lat1, lat2, leak;
    run_div(32'd81, 32'd9, 1'b0, got1, lat1, leak);
    release_div();
    run_div(32'hFFFFFF9C, 32'd7, 1'b1, got2, lat2, leak);
    tests_run++;
    if (lat1 !== 33 || lat2 !== 33 || got1 !== ref_div(32'd81, 32'd9, 1'b0) ||
        got2 !== ref_div(32'hFFFFFF9C, 32'd7, 1'b1)) begin
      fails++;
      $display("FAIL back_to_back: lat=%0d/%0d result=%h/%h, required lat=33/33 result=%h/%h",
               lat1, lat2, got1, got2, ref_div(32'd81, 32'd9, 1'b0), ref_div(32'hFFFFFF9C, 32'd7, 1'b1));
    end
    release_div();
  endtask

  task automatic test_random();
    logic [63:0] got, exp;
    logic [31:0] a, b;
    logic        s;
    int lat, leak, exp_lat;
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      b = $urandom;
      s = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
        0: b = 32'h0;
        1: b = 32'h1;
        2: b = 32'hFFFFFFFF;
        3: a = 32'h80000000;
        4: b = $urandom_range(1, 300);
        default: ;
      endcase
      exp     = ref_div(a, b, s);
      exp_lat = (b == 32'h0) ? 1 : 33;
      run_div(a, b, s, got, lat, leak);
      tests_run++;
      if (lat !== exp_lat || got !== exp || leak != 0) begin
        fails++;
        $display("FAIL random_%0d: a=%h b=%h s=%b latency=%0d result=%h leak=%0d, required latency=%0d result=%h leak=0",
                 i, a, b, s, lat, got, leak, exp_lat, exp);
      end
      release_div();
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_div_zero();
    test_annul();
    test_reset_midop();
    test_overflow_hold();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have: clk  input  1  clock; all state changes occur on the rising edge.
REQ-002 SHALL have: rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have: signed_div_i  input  1  1 = signed (DIV), 0 = unsigned (DIVU).
REQ-004 SHALL have: opdata1_i  input  32  dividend.
REQ-005 SHALL have: opdata2_i  input  32  divisor.
REQ-006 SHALL have: start_i  input  1  EX-stage request; held high until EX has taken the result.
REQ-007 SHALL have: annul_i  input  1  cancel the request, e.g. on a pipeline flush.
REQ-008 SHALL have: result_o  output  64  {remainder[63:32], quotient[31:0]}; registered.
REQ-009 SHALL have: ready_o  output  1  result_o is valid; registered.

Function
REQ-010 SHALL implement a 4-state FSM: FREE, BYZERO, ON, END.
REQ-011 FREE, at an edge with start_i=1 and annul_i=0:
  - SHALL latch opdata1_i, opdata2_i and signed_div_i.
  - SHALL go to BYZERO if opdata2_i==0, otherwise go to ON with iteration counter cnt=0.
REQ-012 FREE with start_i=0 or annul_i=1 SHALL stay in FREE.
REQ-013 Operand changes after the latch edge SHALL NOT affect the result.
REQ-014 Signed mode, operand MSB=1: that operand SHALL be replaced by its two's-complement magnitude before iterating.
REQ-015 ON with annul_i=0 and cnt<32:
  - SHALL perform one restoring shift-subtract step per cycle, producing one quotient bit, MSB first.
  - SHALL increment cnt (6-bit counter).
REQ-016 ON with cnt==32:
  - SHALL apply sign fix-up in signed mode: quotient negated iff dividend sign != divisor sign; remainder negated iff dividend negative.
  - SHALL load result_o, set ready_o=1 and go to END.
REQ-017 ON with annul_i=1 at any edge SHALL go to FREE with ready_o=0, result_o=0 and no result produced; annul_i has priority over iteration.
REQ-018 BYZERO SHALL go to END at the next edge with result_o=64'h0 and ready_o=1.
REQ-019 END SHALL hold result_o and ready_o stable while start_i=1.
REQ-020 END at an edge with start_i=0 SHALL go to FREE, clear ready_o to 0 and clear result_o to 0.
REQ-021 Latency: with edge N the FREE edge that accepts start_i:
  - non-zero divisor: ready_o=1 after edge N+33;
  - zero divisor: ready_o=1 after edge N+1.
REQ-022 start_i while in ON, BYZERO or END SHALL NOT restart the operation.
REQ-023 A new request SHALL be accepted only from FREE, so back-to-back divides require one start_i=0 edge in END.
REQ-024 ready_o SHALL be 0 in every state except END.
REQ-025 result_o SHALL be 0 whenever ready_o=0.
REQ-026 Signed 0x80000000 / 0xFFFFFFFF SHALL give quotient 0x80000000 and remainder 0; no trap, no flag.
REQ-027 All internal arithmetic SHALL be 65-bit (dividend/remainder shift register plus borrow bit); no width truncation before the final 32-bit split.

Reset
REQ-028 rst=1 at an edge SHALL force state=FREE, cnt=0, ready_o=0, result_o=64'h0, and clear the latched operands.
REQ-029 rst SHALL override all other inputs.
REQ-030 rst asserted mid-operation (ON, BYZERO or END) SHALL abort the operation with no result.
REQ-031 The first request after rst deasserts SHALL be accepted at the first edge with start_i=1 and annul_i=0.

Verification
REQ-032 Unsigned: op1=0xFFFFFFFF, op2=2, signed=0, start held -> ready_o rises after edge N+33, result_o=0x00000001_7FFFFFFF.
REQ-033 Signed: op1=0xFFFFFFF9 (-7), op2=2 -> result_o=0xFFFFFFFF_FFFFFFFD (rem -1, quot -3); op1=7, op2=0xFFFFFFFE -> result_o=0x00000001_FFFFFFFD.
REQ-034 Divide by zero: op1=0x12345678, op2=0 -> ready_o=1 after edge N+1, result_o=0; start_i dropped -> ready_o=0 at the next edge.
REQ-035 Annul: start accepted, annul_i=1 at edge N+10 -> FREE, ready_o stays 0 through edge N+40; a fresh request 100/7 then yields 0x00000002_0000000E.
REQ-036 Reset mid-op: rst=1 at edge N+20 -> ready_o=0, result_o=0 thereafter; a new request after rst completes with the correct latency.
REQ-037 Overflow and hold: signed 0x80000000/0xFFFFFFFF -> 0x00000000_80000000; result stays stable for 5 cycles with start_i held high, and opdata changes during ON do not alter it.
